// File: rtl/tcm_dport_arbiter.sv
// Two-port arbiter for the TCM data port.
// The CPU core and the SPI slave share one TCM data port. Only one
// transaction is ever outstanding. A starvation counter stops either side
// from monopolising the port while the other side waits.
//
// Handshake: a request is active while rd=1 or wr!=0. It transfers to memory
// on the cycle where mem_accept_i=1 while the request is active. Exactly one
// mem_ack_i later completes it, and the response is valid in that cycle only.
module tcm_dport_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter bit          SPI_PRIO     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    // core request / response
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_data_wr_i,
    input  logic        core_rd_i,
    input  logic [3:0]  core_wr_i,
    input  logic [10:0] core_req_tag_i,
    output logic        core_accept_o,
    output logic        core_ack_o,
    output logic [31:0] core_data_rd_o,
    output logic [10:0] core_resp_tag_o,
    output logic        core_error_o,
    // SPI request / response
    input  logic [31:0] spi_addr_i,
    input  logic [31:0] spi_data_wr_i,
    input  logic        spi_rd_i,
    input  logic [3:0]  spi_wr_i,
    output logic        spi_accept_o,
    output logic        spi_ack_o,
    output logic [31:0] spi_data_rd_o,
    // shared TCM port
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_wr_o,
    output logic        mem_rd_o,
    output logic [3:0]  mem_wr_o,
    output logic [10:0] mem_req_tag_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_rd_i,
    input  logic [10:0] mem_resp_tag_i,
    input  logic        mem_error_i,
    // status
    output logic        spi_owner_o,
    output logic        spurious_ack_o
);

    localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_CORE = 2'd1,
        GRANT_SPI  = 2'd2,
        WAIT_ACK   = 2'd3
    } state_t;

    state_t        state_q;
    logic          owner_q;      // 1 = SPI owns (or last owned) the port
    logic [CW-1:0] cnt_q;        // consecutive grants to owner_q while the other waited
    logic          spurious_q;

    logic          core_pend;
    logic          spi_pend;
    logic          pick_spi;
    logic          other_pend;
    logic [CW-1:0] cnt_d;

    assign core_pend = core_rd_i | (|core_wr_i);
    assign spi_pend  = spi_rd_i  | (|spi_wr_i);

    // Arbitration decision and the counter value that goes with it
    always_comb begin
        pick_spi   = 1'b0;
        other_pend = 1'b0;
        cnt_d      = '0;
        if (spi_pend && !core_pend) begin
            pick_spi = 1'b1;
        end else if (spi_pend && core_pend) begin
            // Once the owner has hit the limit, the waiting side wins the tie
            if (cnt_q >= CW'(STARVE_LIMIT)) pick_spi = ~owner_q;
            else                            pick_spi = SPI_PRIO;
        end
        other_pend = pick_spi ? core_pend : spi_pend;
        if (!other_pend)            cnt_d = '0;
        else if (pick_spi == owner_q) cnt_d = cnt_q + 1'b1;
        else                        cnt_d = CW'(1);
    end

    // Control FSM, owner, starvation counter and spurious-ack flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            cnt_q      <= '0;
            spurious_q <= 1'b0;
        end else begin
            spurious_q <= mem_ack_i && (state_q != WAIT_ACK);
            case (state_q)
                IDLE: begin
                    if (core_pend || spi_pend) begin
                        state_q <= pick_spi ? GRANT_SPI : GRANT_CORE;
                        owner_q <= pick_spi;
                        cnt_q   <= cnt_d;
                    end
                end
                GRANT_CORE: begin
                    if (!core_pend)        state_q <= IDLE;
                    else if (mem_accept_i) state_q <= WAIT_ACK;
                end
                GRANT_SPI: begin
                    if (!spi_pend)         state_q <= IDLE;
                    else if (mem_accept_i) state_q <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (mem_ack_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic grant_core;
    logic grant_spi;
    logic ack_phase;

    assign grant_core = (state_q == GRANT_CORE);
    assign grant_spi  = (state_q == GRANT_SPI);
    assign ack_phase  = (state_q == WAIT_ACK) && mem_ack_i;

    // Route the owner's request to the TCM port; idle port drives zeros
    always_comb begin
        mem_addr_o    = '0;
        mem_data_wr_o = '0;
        mem_rd_o      = 1'b0;
        mem_wr_o      = '0;
        mem_req_tag_o = '0;
        if (grant_core) begin
            mem_addr_o    = core_addr_i;
            mem_data_wr_o = core_data_wr_i;
            mem_rd_o      = core_rd_i;
            mem_wr_o      = core_wr_i;
            mem_req_tag_o = core_req_tag_i;
        end else if (grant_spi) begin
            mem_addr_o    = spi_addr_i;
            mem_data_wr_o = spi_data_wr_i;
            mem_rd_o      = spi_rd_i;
            mem_wr_o      = spi_wr_i;
            mem_req_tag_o = '0;
        end
    end

    assign core_accept_o   = grant_core & mem_accept_i;
    assign spi_accept_o    = grant_spi  & mem_accept_i;

    // The response goes only to the owner; SPI never sees mem_error_i
    assign core_ack_o      = ack_phase & ~owner_q;
    assign core_data_rd_o  = core_ack_o ? mem_data_rd_i  : '0;
    assign core_resp_tag_o = core_ack_o ? mem_resp_tag_i : '0;
    assign core_error_o    = core_ack_o & mem_error_i;
    assign spi_ack_o       = ack_phase & owner_q;
    assign spi_data_rd_o   = spi_ack_o ? mem_data_rd_i : '0;

    assign spi_owner_o     = grant_spi | ((state_q == WAIT_ACK) & owner_q);
    assign spurious_ack_o  = spurious_q;

endmodule

// File: tb/tb_tcm_dport_arbiter.sv
// Directed bench for tcm_dport_arbiter (STARVE_LIMIT=8, SPI_PRIO=1).
module tb_tcm_dport_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] core_addr_i, core_data_wr_i;
  logic        core_rd_i;
  logic [3:0]  core_wr_i;
  logic [10:0] core_req_tag_i;
  logic        core_accept_o, core_ack_o, core_error_o;
  logic [31:0] core_data_rd_o;
  logic [10:0] core_resp_tag_o;
  logic [31:0] spi_addr_i, spi_data_wr_i;
  logic        spi_rd_i;
  logic [3:0]  spi_wr_i;
  logic        spi_accept_o, spi_ack_o;
  logic [31:0] spi_data_rd_o;
  logic [31:0] mem_addr_o, mem_data_wr_o;
  logic        mem_rd_o;
  logic [3:0]  mem_wr_o;
  logic [10:0] mem_req_tag_o;
  logic        mem_accept_i, mem_ack_i, mem_error_i;
  logic [31:0] mem_data_rd_i;
  logic [10:0] mem_resp_tag_i;
  logic        spi_owner_o, spurious_ack_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mem_model [logic [31:0]];

  tcm_dport_arbiter #(.STARVE_LIMIT(8), .SPI_PRIO(1'b1)) dut (
    .clock(clock), .reset(reset),
    .core_addr_i(core_addr_i), .core_data_wr_i(core_data_wr_i), .core_rd_i(core_rd_i),
    .core_wr_i(core_wr_i), .core_req_tag_i(core_req_tag_i),
    .core_accept_o(core_accept_o), .core_ack_o(core_ack_o), .core_data_rd_o(core_data_rd_o),
    .core_resp_tag_o(core_resp_tag_o), .core_error_o(core_error_o),
    .spi_addr_i(spi_addr_i), .spi_data_wr_i(spi_data_wr_i), .spi_rd_i(spi_rd_i),
    .spi_wr_i(spi_wr_i), .spi_accept_o(spi_accept_o), .spi_ack_o(spi_ack_o),
    .spi_data_rd_o(spi_data_rd_o),
    .mem_addr_o(mem_addr_o), .mem_data_wr_o(mem_data_wr_o), .mem_rd_o(mem_rd_o),
    .mem_wr_o(mem_wr_o), .mem_req_tag_o(mem_req_tag_o),
    .mem_accept_i(mem_accept_i), .mem_ack_i(mem_ack_i), .mem_data_rd_i(mem_data_rd_i),
    .mem_resp_tag_i(mem_resp_tag_i), .mem_error_i(mem_error_i),
    .spi_owner_o(spi_owner_o), .spurious_ack_o(spurious_ack_o)
  );

  // clock / reset block
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs are changed 1 ns after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    core_addr_i = '0; core_data_wr_i = '0; core_rd_i = 1'b0; core_wr_i = '0; core_req_tag_i = '0;
    spi_addr_i = '0; spi_data_wr_i = '0; spi_rd_i = 1'b0; spi_wr_i = '0;
    mem_accept_i = 1'b0; mem_ack_i = 1'b0; mem_error_i = 1'b0;
    mem_data_rd_i = '0; mem_resp_tag_i = '0;
  endtask

  initial begin
    int spi_grants;
    int hs;
    logic core_seen;
    logic hs_prev;

    clear_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    // reset state
    check("rst_mem_rd", mem_rd_o, 0);
    check("rst_mem_wr", mem_wr_o, 0);
    check("rst_spi_owner", spi_owner_o, 0);
    check("rst_spurious", spurious_ack_o, 0);
    check("rst_core_accept", core_accept_o, 0);
    reset = 1'b0;
    tick();

    // core read, accepted at once, acked one cycle later
    core_rd_i = 1'b1; core_addr_i = 32'h8000_0000; core_req_tag_i = 11'h005; mem_accept_i = 1'b1;
    settle();
    check("rd_idle_mem_rd", mem_rd_o, 0);
    tick();
    check("rd_grant_mem_rd", mem_rd_o, 1);
    check("rd_grant_addr", mem_addr_o, 32'h8000_0000);
    check("rd_grant_tag", mem_req_tag_o, 11'h005);
    check("rd_core_accept", core_accept_o, 1);
    check("rd_spi_accept", spi_accept_o, 0);
    tick();
    core_rd_i = 1'b0; mem_accept_i = 1'b0;
    mem_ack_i = 1'b1; mem_data_rd_i = 32'h0000_006F; mem_resp_tag_i = 11'h005;
    settle();
    check("rd_core_ack", core_ack_o, 1);
    check("rd_core_data", core_data_rd_o, 32'h0000_006F);
    check("rd_core_tag", core_resp_tag_o, 11'h005);
    check("rd_spi_ack", spi_ack_o, 0);
    check("rd_wait_mem_rd", mem_rd_o, 0);
    tick();
    clear_inputs();

    // simultaneous requests: SPI wins, core follows after the IDLE cycle
    core_rd_i = 1'b1; core_addr_i = 32'h0000_0100; core_req_tag_i = 11'h00A;
    spi_rd_i = 1'b1; spi_addr_i = 32'h0000_0200; mem_accept_i = 1'b1;
    tick();
    check("tie_spi_owner", spi_owner_o, 1);
    check("tie_spi_addr", mem_addr_o, 32'h0000_0200);
    check("tie_spi_tag", mem_req_tag_o, 0);
    check("tie_spi_accept", spi_accept_o, 1);
    check("tie_core_accept", core_accept_o, 0);
    tick();
    spi_rd_i = 1'b0; mem_ack_i = 1'b1; mem_data_rd_i = 32'hA5A5_0001; mem_error_i = 1'b0;
    settle();
    check("tie_spi_ack", spi_ack_o, 1);
    check("tie_spi_data", spi_data_rd_o, 32'hA5A5_0001);
    check("tie_core_ack", core_ack_o, 0);
    check("tie_core_data", core_data_rd_o, 0);
    check("tie_wait_owner", spi_owner_o, 1);
    tick();
    mem_ack_i = 1'b0;
    settle();
    check("tie_idle_gap", mem_rd_o, 0);
    tick();
    check("tie_core_addr", mem_addr_o, 32'h0000_0100);
    check("tie_core_grant", core_accept_o, 1);
    check("tie_core_not_spi", spi_owner_o, 0);
    tick();
    core_rd_i = 1'b0; mem_ack_i = 1'b1;
    tick();
    clear_inputs();

    // starvation: SPI streams writes while the core holds a read
    core_rd_i = 1'b1; core_addr_i = 32'h0000_0300;
    spi_wr_i = 4'hF; spi_addr_i = 32'h0000_0040; spi_data_wr_i = 32'h1111_2222;
    mem_accept_i = 1'b1;
    spi_grants = 0; core_seen = 1'b0; hs_prev = 1'b0;
    for (int c = 0; c < 60; c++) begin
      mem_ack_i = hs_prev;
      settle();
      if (core_accept_o) begin
        core_seen = 1'b1;
        break;
      end
      if (spi_accept_o && mem_wr_o == 4'hF) spi_grants++;
      hs_prev = (mem_rd_o || mem_wr_o != 4'h0) && mem_accept_i;
      tick();
    end
    check("starve_core_seen", core_seen, 1);
    check("starve_spi_grants", spi_grants, 8);
    tick();
    core_rd_i = 1'b0; spi_wr_i = 4'h0; mem_ack_i = 1'b1;
    settle();
    check("starve_core_ack", core_ack_o, 1);
    tick();
    clear_inputs();

    // back-pressure: accept held low for 5 cycles while SPI waits
    core_wr_i = 4'b0011; core_addr_i = 32'h0000_0044; core_data_wr_i = 32'hCAFE_F00D;
    core_req_tag_i = 11'h7FF; mem_accept_i = 1'b0;
    hs = 0;
    tick();
    spi_rd_i = 1'b1; spi_addr_i = 32'h0000_0088;
    for (int c = 0; c < 5; c++) begin
      settle();
      check("bp_wr", mem_wr_o, 4'b0011);
      check("bp_addr", mem_addr_o, 32'h0000_0044);
      check("bp_data", mem_data_wr_o, 32'hCAFE_F00D);
      check("bp_tag", mem_req_tag_o, 11'h7FF);
      check("bp_spi_accept", spi_accept_o, 0);
      if (mem_wr_o != 4'h0 && mem_accept_i) hs++;
      tick();
    end
    mem_accept_i = 1'b1;
    settle();
    check("bp_core_accept", core_accept_o, 1);
    check("bp_spi_accept_hs", spi_accept_o, 0);
    if (mem_wr_o != 4'h0 && mem_accept_i) hs++;
    tick();
    core_wr_i = 4'h0; spi_rd_i = 1'b0; mem_accept_i = 1'b0;
    mem_ack_i = 1'b1; mem_error_i = 1'b1; mem_resp_tag_i = 11'h7FF;
    settle();
    if (mem_wr_o != 4'h0 && mem_accept_i) hs++;
    check("bp_handshakes", hs, 1);
    check("bp_core_error", core_error_o, 1);
    check("bp_core_resp_tag", core_resp_tag_o, 11'h7FF);
    tick();
    clear_inputs();

    // SPI write with a memory error, then core reads the same word back
    spi_wr_i = 4'hF; spi_addr_i = 32'h0000_0010; spi_data_wr_i = 32'h1234_5678; mem_accept_i = 1'b1;
    tick();
    check("sw_mem_wr", mem_wr_o, 4'hF);
    check("sw_mem_data", mem_data_wr_o, 32'h1234_5678);
    mem_model[mem_addr_o] = mem_data_wr_o;
    tick();
    spi_wr_i = 4'h0; mem_ack_i = 1'b1; mem_error_i = 1'b1;
    settle();
    check("sw_spi_ack", spi_ack_o, 1);
    check("sw_core_error", core_error_o, 0);
    tick();
    clear_inputs();
    core_rd_i = 1'b1; core_addr_i = 32'h0000_0010; core_req_tag_i = 11'h123; mem_accept_i = 1'b1;
    tick();
    check("cr_mem_addr", mem_addr_o, 32'h0000_0010);
    tick();
    core_rd_i = 1'b0; mem_ack_i = 1'b1; mem_resp_tag_i = 11'h123;
    mem_data_rd_i = mem_model.exists(32'h0000_0010) ? mem_model[32'h0000_0010] : 32'h0;
    settle();
    check("cr_core_data", core_data_rd_o, 32'h1234_5678);
    tick();
    clear_inputs();

    // reset during WAIT_ACK, ack after release is spurious
    spi_rd_i = 1'b1; spi_addr_i = 32'h0000_0020; mem_accept_i = 1'b1;
    tick();
    tick();
    spi_rd_i = 1'b0; mem_accept_i = 1'b0;
    settle();
    check("rs_wait_owner", spi_owner_o, 1);
    reset = 1'b1;
    settle();
    check("rs_async_owner", spi_owner_o, 0);
    tick();
    reset = 1'b0;
    mem_ack_i = 1'b1; mem_data_rd_i = 32'hDEAD_BEEF;
    settle();
    check("rs_core_ack", core_ack_o, 0);
    check("rs_spi_ack", spi_ack_o, 0);
    tick();
    mem_ack_i = 1'b0;
    settle();
    check("rs_spurious_hi", spurious_ack_o, 1);
    tick();
    check("rs_spurious_lo", spurious_ack_o, 0);
    clear_inputs();

    // owner drops before accept; illegal rd+wr is forwarded unchanged
    core_rd_i = 1'b1; mem_accept_i = 1'b0;
    tick();
    check("drop_grant_rd", mem_rd_o, 1);
    core_rd_i = 1'b0;
    tick();
    check("drop_idle_rd", mem_rd_o, 0);
    core_rd_i = 1'b1; core_wr_i = 4'hF;
    tick();
    check("ill_rd", mem_rd_o, 1);
    check("ill_wr", mem_wr_o, 4'hF);
    core_rd_i = 1'b0; core_wr_i = 4'h0;
    tick();
    check("ill_back_idle", mem_wr_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tcm_dport_arbiter.md
TCM_DPORT_ARBITER -- requirements
Module: tcm_dport_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: maximum consecutive grants to one requester while the other is pending.
REQ-002 SHALL have parameter SPI_PRIO, default 1: tie-break winner, 1 = SPI, 0 = core.
REQ-003 SHALL have port clock  in  1: clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1: reset, asynchronous, active-high.
REQ-005 SHALL have core ports core_addr_i in 32, core_data_wr_i in 32, core_rd_i in 1, core_wr_i in 4, core_req_tag_i in 11: core data request.
REQ-006 SHALL have core ports core_accept_o out 1, core_ack_o out 1, core_data_rd_o out 32, core_resp_tag_o out 11, core_error_o out 1: core response.
REQ-007 SHALL have SPI ports spi_addr_i in 32, spi_data_wr_i in 32, spi_rd_i in 1, spi_wr_i in 4: SPI-slave data request.
REQ-008 SHALL have SPI ports spi_accept_o out 1, spi_ack_o out 1, spi_data_rd_o out 32: SPI response.
REQ-009 SHALL have TCM ports mem_addr_o out 32, mem_data_wr_o out 32, mem_rd_o out 1, mem_wr_o out 4, mem_req_tag_o out 11: shared TCM data port request.
REQ-010 SHALL have TCM ports mem_accept_i in 1, mem_ack_i in 1, mem_data_rd_i in 32, mem_resp_tag_i in 11, mem_error_i in 1: TCM response.
REQ-011 SHALL have status ports spi_owner_o out 1 (SPI currently granted) and spurious_ack_o out 1 (one-cycle pulse on an unexpected ack).

Function
REQ-012 A requester is pending when its rd is 1 or its wr is nonzero; rd and wr both active is an illegal request and SHALL be forwarded unchanged.
REQ-013 The FSM SHALL have states IDLE, GRANT_CORE, GRANT_SPI and WAIT_ACK.
REQ-014 In IDLE, a single pending requester SHALL be granted the next cycle; both pending SHALL resolve per SPI_PRIO unless REQ-019 applies.
REQ-015 In a GRANT state, the owner's addr, data_wr, rd, wr and tag (SPI tag = 0) SHALL drive mem_* combinationally; owner accept_o = mem_accept_i.
REQ-016 A mem handshake (request active and mem_accept_i = 1) in a GRANT state SHALL move the FSM to WAIT_ACK.
REQ-017 If the owner drops its request before being accepted, the FSM SHALL return to IDLE with no mem transaction.
REQ-018 In WAIT_ACK, mem_ack_i SHALL produce, in the same cycle, owner ack_o = 1 with data_rd_o = mem_data_rd_i; core also gets resp_tag/error from mem. The FSM SHALL then go to IDLE.
REQ-019 The starvation counter SHALL increment per grant to the same requester while the other is pending, and reset to 1 on a grant to the other requester or to 0 when the other is idle; at STARVE_LIMIT the other requester SHALL win the next arbitration.
REQ-020 At most one transaction SHALL be outstanding, so request-to-mem latency is 1 cycle from IDLE and the minimum issue interval is 3 cycles.
REQ-021 Outside GRANT states, mem_rd_o SHALL be 0 and mem_wr_o SHALL be 0; the mem_addr_o, mem_data_wr_o and mem_req_tag_o values are don't-care.
REQ-022 A non-owner's accept_o and ack_o SHALL be 0, and its data_rd_o SHALL be 0.
REQ-023 mem_ack_i outside WAIT_ACK SHALL be ignored and SHALL pulse spurious_ack_o for one cycle.
REQ-024 mem_error_i on an SPI transaction SHALL complete normally, with no error signalled to SPI.
REQ-025 spi_owner_o SHALL be 1 in GRANT_SPI, and in WAIT_ACK when the owner is SPI.

Reset
REQ-026 On reset assertion, the FSM SHALL go to IDLE, the owner to core, the counter to 0, and all outputs to 0, asynchronously.
REQ-027 Reset mid-transaction SHALL drop the outstanding transaction; an ack arriving after reset release SHALL be treated per REQ-023.
REQ-028 The first arbitration SHALL occur on the first rising clock edge after reset deassertion.

Verification
REQ-029 Core read only, addr 0x80000000, tag 0x005, TCM accepts at once, ack 1 cycle later with 0x0000006F -> core_ack_o=1, core_data_rd_o=0x0000006F, core_resp_tag_o=0x005; spi_ack_o=0.
REQ-030 Core and SPI request in the same cycle, SPI_PRIO=1 -> SPI transaction completes first; the core is then granted in the IDLE cycle after SPI's ack.
REQ-031 SPI streams writes (wr=0xF) continuously while the core holds a read, STARVE_LIMIT=8 -> the core is granted after exactly 8 SPI grants.
REQ-032 Hold mem_accept_i=0 for 5 cycles -> owner signals stay stable on mem_*; the non-owner's accept_o stays 0 throughout; one handshake results.
REQ-033 Assert reset in WAIT_ACK, then ack after release -> no ack_o to either requester; spurious_ack_o pulses once.
REQ-034 SPI write of 0x12345678 to 0x10, then core read of 0x10 -> core_data_rd_o=0x12345678.
